tcp_tx_ctrl: RTL and testbench

Transmit-side responder for the TCP connection state manager's `tx_ctrl` command interface. Accepts SYN, ACK and FIN/ACK commands and latches the sequence, acknowledgment, port and address fields. Computes the TCP checksum over the pseudo-header and the 20-byte header, then streams the header as bytes to the IPv4 transmit path. Owns the send sequence counter `snd_nxt` for the single connection.

---
 rtl/tcp_pkg.sv | 27 ++
 rtl/tcp_csum_accum.sv | 36 +++
 rtl/tcp_tx_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_tcp_tx_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP types and constants for the connection state manager and its
// transmit/receive helpers.
//   tx_ctrl_t      : command from the state manager to the transmit controller
//   tcp_tx_state_t : transmit controller FSM states
package tcp_pkg;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    SEND_SYN = 2'd1,
    SEND_ACK = 2'd2,
    SEND_FIN = 2'd3
  } tx_ctrl_t;

  localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
  localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
  localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

  localparam int unsigned TCP_HDR_BYTES = 20;
  localparam logic [7:0]  TCP_PROTO     = 8'h06;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSum  = 2'd1,
    StSend = 2'd2
  } tcp_tx_state_t;

endpackage

// File: rtl/tcp_csum_accum.sv
// 16-bit one's-complement accumulator.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : zero the accumulator (wins over i_add)
//   i_add        : add i_data this cycle
//   i_data       : 16-bit word to add
//   o_sum        : folded running sum (caller inverts for a checksum)
module tcp_csum_accum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [15:0] i_data,
  output logic [15:0] o_sum
);

  logic [15:0] acc_q;
  logic [16:0] raw;
  logic [15:0] acc_d;

  // End-around carry is folded in the same cycle; 0xFFFE+1 cannot carry again.
  always_comb begin
    raw   = {1'b0, acc_q} + {1'b0, i_data};
    acc_d = raw[15:0] + {15'd0, raw[16]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      acc_q <= 16'h0000;
    end else if (i_add) begin
      acc_q <= acc_d;
    end
  end

  assign o_sum = acc_q;

endmodule

// File: rtl/tcp_tx_ctrl.sv
// Transmit-side responder for the TCP state manager's tx_ctrl interface.
// Accepts SYN/ACK/FIN commands in IDLE, latches header fields, sums the
// pseudo-header plus header over 16 cycles, then streams the 20-byte header.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_enable            : gates command acceptance only
//   i_tx_ctrl(_valid)   : command and valid; o_tx_ctrl_ack pulses on accept
//   i_src_ip..i_window  : header / pseudo-header fields
//   o_snd_nxt           : send sequence counter
//   o_busy              : not idle
//   m_axis_*            : header byte stream
module tcp_tx_ctrl
  import tcp_pkg::*;
#(
  parameter logic [15:0] WINDOW_DEFAULT = 16'h0400
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  tx_ctrl_t    i_tx_ctrl,
  input  logic        i_tx_ctrl_valid,
  output logic        o_tx_ctrl_ack,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [31:0] i_iss,
  input  logic [31:0] i_rcv_nxt,
  input  logic [15:0] i_window,
  output logic [31:0] o_snd_nxt,
  output logic        o_busy,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam logic [4:0] LastByte = 5'(TCP_HDR_BYTES - 1);

  tcp_tx_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] snd_nxt_q, seq_q, ack_q, src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, window_q;
  logic [7:0]  flags_q;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic        accept;
  logic [15:0] sum_word, csum_acc, csum;
  logic [4:0]  byte_idx;
  logic [7:0]  hdr_byte;

  assign accept = (state_q == StIdle) && i_enable && i_tx_ctrl_valid &&
                  (i_tx_ctrl != NOP) && !i_rst;
  assign csum   = ~csum_acc;

  tcp_csum_accum u_csum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (accept),
    .i_add  (state_q == StSum),
    .i_data (sum_word),
    .o_sum  (csum_acc)
  );

  // Pseudo-header then header, checksum field counted as zero.
  always_comb begin
    sum_word = 16'h0000;
    unique case (cnt_q[3:0])
      4'd0:    sum_word = src_ip_q[31:16];
      4'd1:    sum_word = src_ip_q[15:0];
      4'd2:    sum_word = dst_ip_q[31:16];
      4'd3:    sum_word = dst_ip_q[15:0];
      4'd4:    sum_word = {8'h00, TCP_PROTO};
      4'd5:    sum_word = 16'(TCP_HDR_BYTES);
      4'd6:    sum_word = src_port_q;
      4'd7:    sum_word = dst_port_q;
      4'd8:    sum_word = seq_q[31:16];
      4'd9:    sum_word = seq_q[15:0];
      4'd10:   sum_word = ack_q[31:16];
      4'd11:   sum_word = ack_q[15:0];
      4'd12:   sum_word = {8'h50, flags_q};
      4'd13:   sum_word = window_q;
      default: sum_word = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (byte_idx)
      5'd0:    hdr_byte = src_port_q[15:8];
      5'd1:    hdr_byte = src_port_q[7:0];
      5'd2:    hdr_byte = dst_port_q[15:8];
      5'd3:    hdr_byte = dst_port_q[7:0];
      5'd4:    hdr_byte = seq_q[31:24];
      5'd5:    hdr_byte = seq_q[23:16];
      5'd6:    hdr_byte = seq_q[15:8];
      5'd7:    hdr_byte = seq_q[7:0];
      5'd8:    hdr_byte = ack_q[31:24];
      5'd9:    hdr_byte = ack_q[23:16];
      5'd10:   hdr_byte = ack_q[15:8];
      5'd11:   hdr_byte = ack_q[7:0];
      5'd12:   hdr_byte = 8'h50;
      5'd13:   hdr_byte = flags_q;
      5'd14:   hdr_byte = window_q[15:8];
      5'd15:   hdr_byte = window_q[7:0];
      5'd16:   hdr_byte = csum[15:8];
      5'd17:   hdr_byte = csum[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    byte_idx = 5'd0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSum;
          cnt_d   = 5'd0;
        end
      end
      StSum: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          // Byte 0 needs no checksum, so it can be loaded on the last sum edge.
          state_d  = StSend;
          cnt_d    = 5'd0;
          byte_idx = 5'd0;
          tdata_d  = hdr_byte;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      StSend: begin
        if (tvalid_q && m_axis_tready) begin
          if (cnt_q == LastByte) begin
            state_d  = StIdle;
            cnt_d    = 5'd0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            cnt_d    = cnt_q + 5'd1;
            byte_idx = cnt_q + 5'd1;
            tdata_d  = hdr_byte;
            tlast_d  = (cnt_q == LastByte - 5'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      snd_nxt_q  <= 32'd0;
      seq_q      <= 32'd0;
      ack_q      <= 32'd0;
      src_ip_q   <= 32'd0;
      dst_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
      window_q   <= 16'd0;
      flags_q    <= 8'd0;
    end else if (accept) begin
      src_ip_q   <= i_src_ip;
      dst_ip_q   <= i_dst_ip;
      src_port_q <= i_src_port;
      dst_port_q <= i_dst_port;
      window_q   <= (i_window == 16'd0) ? WINDOW_DEFAULT : i_window;
      case (i_tx_ctrl)
        SEND_SYN: begin
          seq_q     <= i_iss;
          ack_q     <= 32'd0;
          flags_q   <= TCP_FLAG_SYN;
          snd_nxt_q <= i_iss + 32'd1;
        end
        SEND_ACK: begin
          seq_q   <= snd_nxt_q;
          ack_q   <= i_rcv_nxt;
          flags_q <= TCP_FLAG_ACK;
        end
        SEND_FIN: begin
          seq_q     <= snd_nxt_q;
          ack_q     <= i_rcv_nxt;
          flags_q   <= TCP_FLAG_FIN | TCP_FLAG_ACK;
          snd_nxt_q <= snd_nxt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_tx_ctrl_ack = accept;
  assign o_snd_nxt     = snd_nxt_q;
  assign o_busy        = (state_q != StIdle);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Directed bench for tcp_tx_ctrl.
module tb_tcp_tx_ctrl;
  import tcp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  tx_ctrl_t    i_tx_ctrl;
  logic        i_tx_ctrl_valid;
  logic        o_tx_ctrl_ack;
  logic [31:0] i_src_ip, i_dst_ip, i_iss, i_rcv_nxt, o_snd_nxt;
  logic [15:0] i_src_port, i_dst_port, i_window;
  logic        o_busy;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  always #5 i_clk = ~i_clk;

  tcp_tx_ctrl #(.WINDOW_DEFAULT(16'h0200)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_enable        (i_enable),
    .i_tx_ctrl       (i_tx_ctrl),
    .i_tx_ctrl_valid (i_tx_ctrl_valid),
    .o_tx_ctrl_ack   (o_tx_ctrl_ack),
    .i_src_ip        (i_src_ip),
    .i_dst_ip        (i_dst_ip),
    .i_src_port      (i_src_port),
    .i_dst_port      (i_dst_port),
    .i_iss           (i_iss),
    .i_rcv_nxt       (i_rcv_nxt),
    .i_window        (i_window),
    .o_snd_nxt       (o_snd_nxt),
    .o_busy          (o_busy),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] exp_b [20];
  logic [7:0] rx_b  [20];
  int rx_n;
  int tlast_n;
  int first_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Reference header with one's-complement checksum over pseudo-header + header.
  function automatic void build_exp(input logic [31:0] sip, input logic [31:0] dip,
                                    input logic [15:0] sp, input logic [15:0] dp,
                                    input logic [31:0] seq, input logic [31:0] ack,
                                    input logic [7:0] flags, input logic [15:0] win);
    logic [31:0] s;
    logic [15:0] cs;
    s = {16'd0, sip[31:16]} + {16'd0, sip[15:0]} + {16'd0, dip[31:16]} +
        {16'd0, dip[15:0]} + 32'h0006 + 32'h0014 + {16'd0, sp} + {16'd0, dp} +
        {16'd0, seq[31:16]} + {16'd0, seq[15:0]} + {16'd0, ack[31:16]} +
        {16'd0, ack[15:0]} + {16'h0000, 8'h50, flags} + {16'd0, win};
    s  = (s & 32'h0000_FFFF) + (s >> 16);
    s  = (s & 32'h0000_FFFF) + (s >> 16);
    cs = ~s[15:0];
    exp_b[0]  = sp[15:8];    exp_b[1]  = sp[7:0];
    exp_b[2]  = dp[15:8];    exp_b[3]  = dp[7:0];
    exp_b[4]  = seq[31:24];  exp_b[5]  = seq[23:16];
    exp_b[6]  = seq[15:8];   exp_b[7]  = seq[7:0];
    exp_b[8]  = ack[31:24];  exp_b[9]  = ack[23:16];
    exp_b[10] = ack[15:8];   exp_b[11] = ack[7:0];
    exp_b[12] = 8'h50;       exp_b[13] = flags;
    exp_b[14] = win[15:8];   exp_b[15] = win[7:0];
    exp_b[16] = cs[15:8];    exp_b[17] = cs[7:0];
    exp_b[18] = 8'h00;       exp_b[19] = 8'h00;
  endfunction

  // Receive up to max_bytes, checking each against exp_b; rnd enables backpressure.
  task automatic collect(input int max_bytes, input bit rnd);
    int   cyc;
    logic stalled;
    logic [7:0] held;
    logic held_last;
    cyc = 0; stalled = 1'b0; held = 8'h00; held_last = 1'b0;
    rx_n = 0; tlast_n = 0;
    while (rx_n < max_bytes && cyc < 400) begin
      if (stalled) begin
        check("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("stall_tdata", {24'd0, m_axis_tdata}, {24'd0, held});
        check("stall_tlast", {31'd0, m_axis_tlast}, {31'd0, held_last});
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        rx_b[rx_n] = m_axis_tdata;
        check($sformatf("byte%0d", rx_n), {24'd0, m_axis_tdata}, {24'd0, exp_b[rx_n]});
        check($sformatf("tlast%0d", rx_n), {31'd0, m_axis_tlast}, {31'd0, rx_n == 19});
        if (m_axis_tlast) tlast_n++;
        rx_n++;
        stalled = 1'b0;
      end else if (m_axis_tvalid) begin
        stalled   = 1'b1;
        held      = m_axis_tdata;
        held_last = m_axis_tlast;
      end else begin
        stalled = 1'b0;
      end
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
    check("collect_count", rx_n, max_bytes);
  endtask

  task automatic finish_checks(input string tag);
    check({tag, "_tlast_once"}, tlast_n, 1);
    check({tag, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_idle_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
  endtask

  // Drive a one-cycle command and check the combinational ack.
  task automatic pulse_cmd(input tx_ctrl_t cmd, input logic exp_ack, input string tag);
    i_tx_ctrl       = cmd;
    i_tx_ctrl_valid = 1'b1;
    #1;
    check(tag, {31'd0, o_tx_ctrl_ack}, {31'd0, exp_ack});
    step();
    i_tx_ctrl_valid = 1'b0;
    i_tx_ctrl       = NOP;
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b1; i_tx_ctrl = SEND_SYN; i_tx_ctrl_valid = 1'b1;
    i_src_ip = 32'h0A00_0002; i_dst_ip = 32'h0A00_0001;
    i_src_port = 16'h1234; i_dst_port = 16'h0050;
    i_iss = 32'h1000_0000; i_rcv_nxt = 32'h0; i_window = 16'h0400;
    m_axis_tready = 1'b1;

    // Reset
    #1;
    check("ack_in_reset", {31'd0, o_tx_ctrl_ack}, 32'd0);
    step(); step();
    check("ack_in_reset2", {31'd0, o_tx_ctrl_ack}, 32'd0);
    check("rst_snd_nxt", o_snd_nxt, 32'd0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    i_tx_ctrl_valid = 1'b0; i_tx_ctrl = NOP;
    i_rst = 1'b0;
    step();

    // Enable low blocks a valid SYN
    i_enable = 1'b0;
    i_tx_ctrl = SEND_SYN; i_tx_ctrl_valid = 1'b1;
    #1;
    check("en_low_ack", {31'd0, o_tx_ctrl_ack}, 32'd0);
    step(); step(); step();
    check("en_low_busy", {31'd0, o_busy}, 32'd0);
    check("en_low_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("en_low_snd_nxt", o_snd_nxt, 32'd0);
    i_tx_ctrl_valid = 1'b0; i_tx_ctrl = NOP;
    i_enable = 1'b1;
    step();

    // SYN with latency check
    pulse_cmd(SEND_SYN, 1'b1, "syn_ack");
    check("syn_snd_nxt", o_snd_nxt, 32'h1000_0001);
    check("syn_busy", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < 15; k++) step();
    check("syn_tvalid_T16", {31'd0, m_axis_tvalid}, 32'd0);
    step();
    check("syn_tvalid_T17", {31'd0, m_axis_tvalid}, 32'd1);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'h1000_0000, 32'h0, 8'h02, 16'h0400);
    collect(20, 1'b0);
    finish_checks("syn");
    check("syn_csum_hand", {16'd0, rx_b[16], rx_b[17]}, 32'h0000_755C);

    // ACK with default window, a FIN pulse during SUM, random backpressure
    i_rcv_nxt = 32'hDEAD_BEEF; i_window = 16'h0000;
    pulse_cmd(SEND_ACK, 1'b1, "ack_ack");
    check("ack_snd_nxt", o_snd_nxt, 32'h1000_0001);
    step(); step();
    pulse_cmd(SEND_FIN, 1'b0, "fin_in_sum_ack");
    check("fin_in_sum_snd_nxt", o_snd_nxt, 32'h1000_0001);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'h1000_0001, 32'hDEAD_BEEF, 8'h10, 16'h0200);
    collect(20, 1'b1);
    finish_checks("ack");
    check("ack_snd_nxt_after", o_snd_nxt, 32'h1000_0001);
    check("ack_flags", {24'd0, rx_b[13]}, 32'h10);

    // FIN at snd_nxt = 0xFFFF_FFFF wraps the counter
    i_window = 16'h0400; i_iss = 32'hFFFF_FFFE;
    pulse_cmd(SEND_SYN, 1'b1, "syn2_ack");
    check("syn2_snd_nxt", o_snd_nxt, 32'hFFFF_FFFF);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'hFFFF_FFFE, 32'h0, 8'h02, 16'h0400);
    collect(20, 1'b0);
    finish_checks("syn2");
    i_rcv_nxt = 32'h0123_4567;
    pulse_cmd(SEND_FIN, 1'b1, "fin_ack");
    check("fin_snd_nxt_wrap", o_snd_nxt, 32'h0000_0000);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'hFFFF_FFFF, 32'h0123_4567, 8'h11, 16'h0400);
    collect(20, 1'b1);
    finish_checks("fin");

    // Back-to-back SYN then held ACK: second ack no earlier than T+37
    i_iss = 32'h1000_0000; i_rcv_nxt = 32'hCAFE_0001;
    pulse_cmd(SEND_SYN, 1'b1, "b2b_syn_ack");
    i_tx_ctrl = SEND_ACK; i_tx_ctrl_valid = 1'b1;
    first_ack = 0;
    for (int k = 1; k <= 45 && first_ack == 0; k++) begin
      #1;
      if (o_tx_ctrl_ack) first_ack = k;
      step();
    end
    i_tx_ctrl_valid = 1'b0; i_tx_ctrl = NOP;
    check("b2b_ack_cycle", first_ack, 37);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'h1000_0001, 32'hCAFE_0001, 8'h10, 16'h0400);
    collect(20, 1'b0);
    finish_checks("b2b");

    // Reset at byte 7 of SEND, then a clean SYN
    i_iss = 32'h2000_0000;
    pulse_cmd(SEND_SYN, 1'b1, "rst_syn_ack");
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'h1234, 16'h0050,
              32'h2000_0000, 32'h0, 8'h02, 16'h0400);
    for (int k = 0; k < 16; k++) step();
    collect(7, 1'b0);
    i_rst = 1'b1;
    step();
    check("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_snd_nxt", o_snd_nxt, 32'd0);
    i_rst = 1'b0;
    step();
    i_iss = 32'h3000_0000; i_src_port = 16'hABCD; i_dst_port = 16'h0016;
    pulse_cmd(SEND_SYN, 1'b1, "post_rst_syn_ack");
    check("post_rst_snd_nxt", o_snd_nxt, 32'h3000_0001);
    build_exp(32'h0A00_0002, 32'h0A00_0001, 16'hABCD, 16'h0016,
              32'h3000_0000, 32'h0, 8'h02, 16'h0400);
    collect(20, 1'b1);
    finish_checks("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
